// File: rtl/uart_defs.sv
// -----------------------------------------------------------------------------
// uart_defs
// Definitions shared by the UART receive and transmit blocks.
//   - UART_DW, UART_SLOOP_MAX : default word width and clocks per bit
//   - ST_*                    : 3-bit receiver FSM state encodings
// No ports (package).
// -----------------------------------------------------------------------------
package uart_defs;

  localparam int UART_DW        = 8;
  localparam int UART_SLOOP_MAX = 100;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;
  localparam logic [2:0] ST_BREAK = 3'd5;

endpackage

// File: rtl/uart_sync2.sv
// -----------------------------------------------------------------------------
// uart_sync2
// Generic two-flop synchroniser for a single asynchronous input. Both flops
// reset to 1 so an idle-high line does not look like activity after reset.
// Ports:
//   CLK   in  1  destination clock
//   RST_X in  1  asynchronous active-low reset
//   D     in  1  asynchronous input
//   Q     out 1  synchronised output (second flop)
// -----------------------------------------------------------------------------
module uart_sync2 (
  input  logic CLK,
  input  logic RST_X,
  input  logic D,
  output logic Q
);

  logic meta;

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      meta <= 1'b1;
      Q    <= 1'b1;
    end else begin
      meta <= D;
      Q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_deser.sv
// -----------------------------------------------------------------------------
// uart_rx_deser
// UART receive front end. Synchronises RX, detects the start bit, samples
// each bit and deserialises LSB-first into a DW-bit word.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
// Parameters:
//   DW         data bits per frame
//   SLOOP_MAX  clocks per bit (>= 4)
//   PARITY_ODD parity sense with UART_RX_PARITY_EN (0 even, 1 odd)
// Ports:
//   CLK     in  1   system clock
//   RST_X   in  1   asynchronous active-low reset
//   RX      in  1   serial line, idle high, asynchronous
//   RXDOT   out DW  last good word, held until the next good frame
//   RXVALID out 1   one-cycle pulse, RXDOT is new
//   FERR    out 1   one-cycle pulse, stop bit sampled low
//   PERR    out 1   one-cycle pulse, parity mismatch (0 without the macro)
// -----------------------------------------------------------------------------
module uart_rx_deser
  import uart_defs::*;
#(
  parameter int DW         = UART_DW,
  parameter int SLOOP_MAX  = UART_SLOOP_MAX,
  parameter int PARITY_ODD = 0
) (
  input  logic          CLK,
  input  logic          RST_X,
  input  logic          RX,
  output logic [DW-1:0] RXDOT,
  output logic          RXVALID,
  output logic          FERR,
  output logic          PERR
);

  localparam int CNT_W = $clog2(SLOOP_MAX);
  localparam int IDX_W = $clog2(DW + 1);
  localparam int H     = SLOOP_MAX / 2;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOOP_MAX - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DW - 1);

  logic             rxs;
  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [DW-1:0]    shreg;
  logic             cnt_last;

  assign cnt_last = (cnt == CNT_LAST);

  uart_sync2 u_sync (
    .CLK   (CLK),
    .RST_X (RST_X),
    .D     (RX),
    .Q     (rxs)
  );

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_SENSE = 1'(PARITY_ODD);
  logic par_bit;
  logic par_bad;
  logic perr_q;

  assign par_bad = par_bit ^ (^shreg) ^ PAR_SENSE;
  assign PERR    = perr_q;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = 1'(PARITY_ODD);
  assign PERR              = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      RXDOT   <= '0;
      RXVALID <= 1'b0;
      FERR    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      RXVALID <= 1'b0;
      FERR    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (!rxs) state <= ST_START;
        end
        // Re-check the start bit near its middle to reject short glitches;
        // this also aligns all later samples to mid-bit.
        ST_START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            idx <= '0;
            state <= rxs ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt_last) begin
            // New bit enters at the MSB so the first bit ends up in bit 0.
            shreg <= {rxs, shreg[DW-1:1]};
            cnt   <= '0;
            idx   <= idx + 1'b1;
            if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PAR;
`else
              state <= ST_STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PAR: begin
          if (cnt_last) begin
            par_bit <= rxs;
            cnt     <= '0;
            state   <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (cnt_last) begin
            cnt <= '0;
            if (!rxs) begin
              FERR  <= 1'b1;
              state <= ST_BREAK;
`ifdef UART_RX_PARITY_EN
            end else if (par_bad) begin
              perr_q <= 1'b1;
              state  <= ST_IDLE;
`endif
            end else begin
              RXDOT   <= shreg;
              RXVALID <= 1'b1;
              state   <= ST_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // A held-low line must go high before another start is accepted.
        ST_BREAK: begin
          cnt <= '0;
          if (rxs) state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
